// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: shifts accepted bits into a history register and
// pulses out/bumps a saturating counter when the full window equals the pattern.
module seq_detect_fsm #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       overlap_en,
  input  logic                       pat_load,
  input  logic [PAT_W-1:0]           pat_in,
  output logic                       out,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(PAT_W+1)-1:0] fill
);

  // state  | meaning
  // S_FILL | fewer than PAT_W valid history bits; no match possible
  // S_FULL | history window is completely valid; compare on every accepted bit

  localparam int FW = $clog2(PAT_W+1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W-1);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t            state_q, state_n;
  logic [PAT_W-1:0]  pattern_q, pattern_n;
  logic [PAT_W-1:0]  history_q, history_n;
  logic [FW-1:0]     fill_q, fill_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              out_q, out_n;

  logic [PAT_W-1:0]  hist_shift;
  logic              full_after;
  logic              hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FILL;
      pattern_q <= RST_PAT;
      history_q <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      pattern_q <= pattern_n;
      history_q <= history_n;
      fill_q    <= fill_n;
      cnt_q     <= cnt_n;
      out_q     <= out_n;
    end
  end

  assign hist_shift = {history_q[PAT_W-2:0], in};
  assign full_after = (state_q == S_FULL) || (fill_q == FILL_LAST);
  // Gating on window validity keeps an all-zero pattern from matching cleared history.
  assign hit        = full_after && (hist_shift == pattern_q);

  always_comb begin
    state_n   = state_q;
    pattern_n = pattern_q;
    history_n = history_q;
    fill_n    = fill_q;
    cnt_n     = cnt_q;
    out_n     = 1'b0;

    if (pat_load) begin
      pattern_n = pat_in;
      history_n = '0;
      fill_n    = '0;
      state_n   = S_FILL;
    end else if (in_valid) begin
      history_n = hist_shift;
      fill_n    = full_after ? FILL_FULL : fill_q + FW'(1);
      state_n   = full_after ? S_FULL : S_FILL;
      if (hit) begin
        out_n = 1'b1;
        cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (!overlap_en) begin
          fill_n  = '0;
          state_n = S_FILL;
        end
      end
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule
